control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Parametrised multi-cycle successor to the CPU control unit.
- Explicit state machine fetches instructions over the 8-bit memory bus and stalls on a mem_ready handshake.
- Moves WORD_BYTES-wide registers one byte per cycle, and adds HLT plus a bus-timeout watchdog.
- Drives register/ALU/pointer strobes of the datapath; all strobes active-high.

Parameters:
WORD_BYTES, 1, register width in bytes (1..4); LD/ST/LDI transfer this many bytes
MAX_WAIT, 0, max consecutive wait cycles per access before bus_error; 0 = unbounded

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  synchronous active-high reset
ir  in  8  instruction byte from D bus (valid while ir_we)
flags  in  4  stored ALU flags
mem_ready  in  1  current memory access completes this cycle
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
addr_dp  out  1  0: address = IP, 1: address = DP + byte_sel
byte_sel  out  2  byte lane / DP offset of current transfer
ir_we  out  1  latch D into IR
ip_inc  out  1  IP++ at end of cycle
swap_p  out  1  swap IP and DP at end of cycle
reg_we  out  4  one-hot register write enable (lane byte_sel for memory ops)
reg_oe_d  out  4  one-hot register drive onto D (lane byte_sel)
alu_op  out  4  ALU operation
alu_invert  out  1  swap ALU operand order
alu_oe  out  1  ALU drives DI
flags_we  out  1  latch flags
halted  out  1  sequencer stopped
bus_error  out  1  sticky watchdog timeout

Behaviour:
- Encoding (IR latched internally):
  - ALU 0ooooidd: i=0 → A = ALU(A, r[dd]); i=1 → r[dd] = ALU(r[dd], A), alu_invert = 1.
  - LD 1000xxdd; ST 1001xxdd; LDI 1010xxdd.
  - Jc 11000cff: jump taken iff flags[ff] ^ c.
  - JMP 11001xxx.
  - HLT 11111111.
  - Any other 1xxxxxxx is a NOP.
- States: FETCH, EXEC, XFER, HALT.
- Reset: state = FETCH, byte counter = 0, wait counter = 0, halted = 0, bus_error = 0. All outputs 0 in the reset cycle.
- FETCH:
  - Drives mem_rd = 1, addr_dp = 0.
  - Stays in FETCH while mem_ready = 0.
  - On mem_ready = 1: ir_we = 1, ip_inc = 1, next state EXEC.
- EXEC (always exactly 1 cycle):
  - ALU: alu_oe = 1, flags_we = 1, alu_op = ir[6:3], reg_we per the encoding (A is r[0]). Next FETCH.
  - Jc / JMP: swap_p = 1 when taken (JMP always). Next FETCH.
  - NOP: next FETCH.
  - HLT: next HALT.
  - LD / ST / LDI: byte counter = 0, next XFER; no strobes in this cycle.
- XFER: one byte per completed access, byte_sel = counter.
  - LD: mem_rd = 1, addr_dp = 1, reg_we[dd] = mem_ready.
  - ST: mem_wr = 1, addr_dp = 1, reg_oe_d[dd] = 1 for the whole access.
  - LDI: mem_rd = 1, addr_dp = 0, reg_we[dd] = mem_ready, ip_inc = mem_ready.
  - On mem_ready: counter++. After byte WORD_BYTES-1 completes, go to FETCH and clear the counter.
- Wait states:
  - mem_rd / mem_wr, addr and byte_sel stay stable until mem_ready.
  - No write enables or pointer strobes fire while mem_ready = 0.
- Latency with zero wait states:
  - ALU, Jc, JMP, NOP: 2 cycles.
  - LD, ST, LDI: 2 + WORD_BYTES cycles.
  - Each wait cycle adds 1.
- Watchdog (MAX_WAIT > 0):
  - Counter increments each cycle mem_rd or mem_wr is high with mem_ready = 0; clears on mem_ready or on state change.
  - When the counter reaches MAX_WAIT: bus_error = 1 (sticky), next HALT; the access is abandoned with no strobes.
- HALT: halted = 1, all strobes 0; exit only via rst.
- rst has priority over everything, including mid-XFER, wait states and HALT. Partial register writes already performed are not undone.
- Outputs are combinational from state, latched IR, counters, flags and mem_ready; no internal combinational loops.

Test Plan:
- WORD_BYTES=1, mem_ready tied 1, program ALU (0x08), JMP (0xC8) → each takes 2 cycles; flags_we=1 and alu_op=1 in ALU EXEC; swap_p=1 for exactly 1 cycle in JMP EXEC.
- Jc 0xC1 with flags=4'b0010 → swap_p=1; same instruction with flags=4'b0000 → swap_p=0; 0xC5 with flags=4'b0010 → swap_p=0.
- WORD_BYTES=4, LDI 0xA2, mem_ready=1 → 6 cycles total; reg_we=4'b0100 with byte_sel 0,1,2,3 on consecutive cycles; ip_inc high 5 times.
- WORD_BYTES=2, ST 0x91, mem_ready low 3 cycles on byte 1 → mem_wr, addr_dp=1, byte_sel=1 held 4 cycles; reg_oe_d=4'b0010 throughout; completes in 7 cycles.
- MAX_WAIT=5, LD with mem_ready stuck 0 → bus_error and halted rise after 5 wait cycles; no reg_we pulse; then rst for 1 cycle → FETCH, flags cleared, mem_rd=1 next cycle.
- HLT 0xFF → halted=1 from the cycle after EXEC; mem_rd stays 0 for 20 cycles; rst asserted mid-LDI (WORD_BYTES=4, byte 2) → byte_sel=0 and state FETCH after reset.

Source files
------------

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: memory-bus and datapath-control bundle between the
// control sequencer and the datapath/memory.
//   master (sequencer): receives ir, flags, mem_ready; drives the memory
//                       request, address select and all datapath strobes.
//   slave  (datapath):  the mirror image.
// Signals:
//   ir[7:0]        instruction byte from the D bus (valid while ir_we)
//   flags[3:0]     stored ALU flags
//   mem_ready      current memory access completes this cycle
//   mem_rd/mem_wr  memory read / write request
//   addr_dp        0: address = IP, 1: address = DP + byte_sel
//   byte_sel[1:0]  byte lane / DP offset of the current transfer
//   ir_we, ip_inc, swap_p                 IR latch, IP++, IP<->DP swap
//   reg_we[3:0], reg_oe_d[3:0]            one-hot register write / drive
//   alu_op[3:0], alu_invert, alu_oe, flags_we
//   halted, bus_error                     status
interface control_sequencer_if;
    logic [7:0] ir;
    logic [3:0] flags;
    logic       mem_ready;
    logic       mem_rd;
    logic       mem_wr;
    logic       addr_dp;
    logic [1:0] byte_sel;
    logic       ir_we;
    logic       ip_inc;
    logic       swap_p;
    logic [3:0] reg_we;
    logic [3:0] reg_oe_d;
    logic [3:0] alu_op;
    logic       alu_invert;
    logic       alu_oe;
    logic       flags_we;
    logic       halted;
    logic       bus_error;

    modport master (
        input  ir, flags, mem_ready,
        output mem_rd, mem_wr, addr_dp, byte_sel, ir_we, ip_inc, swap_p, reg_we, reg_oe_d,
               alu_op, alu_invert, alu_oe, flags_we, halted, bus_error
    );

    modport slave (
        output ir, flags, mem_ready,
        input  mem_rd, mem_wr, addr_dp, byte_sel, ir_we, ip_inc, swap_p, reg_we, reg_oe_d,
               alu_op, alu_invert, alu_oe, flags_we, halted, bus_error
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle instruction sequencer. Fetches one opcode
// byte over the 8-bit memory bus, executes it in one cycle, and moves
// WORD_BYTES-wide registers one byte per access for LD/ST/LDI. Every memory
// access stalls on mem_ready; an optional watchdog halts with a sticky
// bus_error when an access waits too long. HLT stops until reset.
// Ports:
//   clk  clock, all state changes on posedge
//   rst  synchronous active-high reset; forces every output low this cycle
//   bus  control_sequencer_if.master (memory handshake + datapath strobes)
// Parameters:
//   WORD_BYTES  register width in bytes (1..4)
//   MAX_WAIT    wait cycles per access before bus_error; 0 disables watchdog
module control_sequencer #(
    parameter int unsigned WORD_BYTES = 1,
    parameter int unsigned MAX_WAIT   = 0
) (
    input logic                 clk,
    input logic                 rst,
    control_sequencer_if.master bus
);

    // Counter only needs to reach MAX_WAIT-1: the next wait cycle trips.
    localparam int unsigned      WaitW    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [1:0]       LastByte = 2'(WORD_BYTES - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {StFetch, StExec, StXfer, StHalt} state_e;

    state_e           state_q, state_d;
    logic [7:0]       ir_q, ir_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             bus_err_q, bus_err_d;

    // Instruction decode of the latched IR
    logic       is_alu, is_st, is_ldi, is_mem, is_jc, is_jmp, is_hlt, jc_taken;
    logic [3:0] dd_onehot;

    assign is_alu    = ~ir_q[7];
    assign is_st     = (ir_q[7:4] == 4'b1001);
    assign is_ldi    = (ir_q[7:4] == 4'b1010);
    assign is_mem    = (ir_q[7:4] == 4'b1000) | is_st | is_ldi;
    assign is_jc     = (ir_q[7:3] == 5'b11000);
    assign is_jmp    = (ir_q[7:3] == 5'b11001);
    assign is_hlt    = (ir_q == 8'hFF);
    assign jc_taken  = bus.flags[ir_q[1:0]] ^ ir_q[2];
    assign dd_onehot = 4'b0001 << ir_q[1:0];

    // Ungated outputs; rst masks them below
    logic       mem_rd, mem_wr, addr_dp, ir_we, ip_inc, swap_p;
    logic       alu_invert, alu_oe, flags_we;
    logic [1:0] byte_sel;
    logic [3:0] reg_we, reg_oe_d, alu_op;

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        cnt_d      = cnt_q;
        wait_d     = '0;
        bus_err_d  = bus_err_q;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        addr_dp    = 1'b0;
        byte_sel   = 2'd0;
        ir_we      = 1'b0;
        ip_inc     = 1'b0;
        swap_p     = 1'b0;
        reg_we     = 4'd0;
        reg_oe_d   = 4'd0;
        alu_op     = 4'd0;
        alu_invert = 1'b0;
        alu_oe     = 1'b0;
        flags_we   = 1'b0;

        unique case (state_q)
            StFetch: begin
                mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    ir_we   = 1'b1;
                    ip_inc  = 1'b1;
                    ir_d    = bus.ir;
                    state_d = StExec;
                end
            end
            StExec: begin
                cnt_d = 2'd0;
                if (is_alu) begin
                    alu_oe   = 1'b1;
                    flags_we = 1'b1;
                    alu_op   = ir_q[6:3];
                    if (ir_q[2]) begin
                        reg_we     = dd_onehot;
                        alu_invert = 1'b1;
                    end else begin
                        reg_we = 4'b0001;
                    end
                    state_d = StFetch;
                end else if (is_mem) begin
                    state_d = StXfer;
                end else if (is_hlt) begin
                    state_d = StHalt;
                end else begin
                    // Jc, JMP and NOP all return to fetch
                    swap_p  = is_jmp | (is_jc & jc_taken);
                    state_d = StFetch;
                end
            end
            StXfer: begin
                byte_sel = cnt_q;
                addr_dp  = ~is_ldi;
                mem_rd   = ~is_st;
                mem_wr   = is_st;
                if (is_st) begin
                    reg_oe_d = dd_onehot;
                end
                if (bus.mem_ready) begin
                    if (!is_st) begin
                        reg_we = dd_onehot;
                    end
                    ip_inc = is_ldi;
                    if (cnt_q == LastByte) begin
                        cnt_d   = 2'd0;
                        state_d = StFetch;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // Watchdog: only wait cycles count; the last one abandons the access
        if ((MAX_WAIT != 0) && (mem_rd || mem_wr) && !bus.mem_ready) begin
            if (wait_q == WaitLast) begin
                state_d   = StHalt;
                bus_err_d = 1'b1;
            end else begin
                wait_d = wait_q + WaitW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            ir_q      <= 8'd0;
            cnt_q     <= 2'd0;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus.mem_rd     = mem_rd & ~rst;
    assign bus.mem_wr     = mem_wr & ~rst;
    assign bus.addr_dp    = addr_dp & ~rst;
    assign bus.byte_sel   = byte_sel & {2{~rst}};
    assign bus.ir_we      = ir_we & ~rst;
    assign bus.ip_inc     = ip_inc & ~rst;
    assign bus.swap_p     = swap_p & ~rst;
    assign bus.reg_we     = reg_we & {4{~rst}};
    assign bus.reg_oe_d   = reg_oe_d & {4{~rst}};
    assign bus.alu_op     = alu_op & {4{~rst}};
    assign bus.alu_invert = alu_invert & ~rst;
    assign bus.alu_oe     = alu_oe & ~rst;
    assign bus.flags_we   = flags_we & ~rst;
    assign bus.halted     = (state_q == StHalt) & ~rst;
    assign bus.bus_error  = bus_err_q & ~rst;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: three instances (WORD_BYTES 1/2/4,
// the 4-byte one with MAX_WAIT=5) share clock, reset and bus inputs; each
// scenario resets all of them and checks the instance it targets.
module tb_control_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ir;
    logic [3:0] flags;
    logic       mem_ready;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    control_sequencer_if b1 ();
    control_sequencer_if b2 ();
    control_sequencer_if b4 ();

    assign b1.ir = ir;
    assign b1.flags = flags;
    assign b1.mem_ready = mem_ready;
    assign b2.ir = ir;
    assign b2.flags = flags;
    assign b2.mem_ready = mem_ready;
    assign b4.ir = ir;
    assign b4.flags = flags;
    assign b4.mem_ready = mem_ready;

    control_sequencer #(.WORD_BYTES(1), .MAX_WAIT(0)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
    control_sequencer #(.WORD_BYTES(2), .MAX_WAIT(0)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));
    control_sequencer #(.WORD_BYTES(4), .MAX_WAIT(5)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));

    // All outputs of one instance packed, for "everything quiet" checks
    logic [24:0] v1, v2, v4;
    assign v1 = {b1.mem_rd, b1.mem_wr, b1.addr_dp, b1.byte_sel, b1.ir_we, b1.ip_inc, b1.swap_p,
                 b1.reg_we, b1.reg_oe_d, b1.alu_op, b1.alu_invert, b1.alu_oe, b1.flags_we,
                 b1.halted, b1.bus_error};
    assign v2 = {b2.mem_rd, b2.mem_wr, b2.addr_dp, b2.byte_sel, b2.ir_we, b2.ip_inc, b2.swap_p,
                 b2.reg_we, b2.reg_oe_d, b2.alu_op, b2.alu_invert, b2.alu_oe, b2.flags_we,
                 b2.halted, b2.bus_error};
    assign v4 = {b4.mem_rd, b4.mem_wr, b4.addr_dp, b4.byte_sel, b4.ir_we, b4.ip_inc, b4.swap_p,
                 b4.reg_we, b4.reg_oe_d, b4.alu_op, b4.alu_invert, b4.alu_oe, b4.flags_we,
                 b4.halted, b4.bus_error};

    // Conditional-jump vectors: opcode, flags, expected swap_p
    logic [7:0] jc_ir   [5] = '{8'hC1, 8'hC1, 8'hC5, 8'hC6, 8'hB3};
    logic [3:0] jc_fl   [5] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b1111};
    logic       jc_swap [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Returns in the first FETCH cycle after reset
    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b0;
        ir        = 8'h00;
        flags     = 4'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned n_ip;
        int unsigned bad;

        rst       = 1'b1;
        ir        = 8'h00;
        flags     = 4'h0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_quiet_d1", v1, 0);
        check_eq("reset_quiet_d4", v4, 0);

        // ALU, JMP, ALU(i=1), then conditional jumps / NOP on WORD_BYTES=1
        do_reset();
        ir = 8'h08;
        mem_ready = 1'b1;
        #1;
        check_eq("fetch_mem_rd", b1.mem_rd, 1);
        check_eq("fetch_ir_we", b1.ir_we, 1);
        check_eq("fetch_ip_inc", b1.ip_inc, 1);
        check_eq("fetch_addr_dp", b1.addr_dp, 0);
        cyc();
        ir = 8'hC8;
        #1;
        check_eq("alu_oe", b1.alu_oe, 1);
        check_eq("alu_flags_we", b1.flags_we, 1);
        check_eq("alu_op", b1.alu_op, 4'd1);
        check_eq("alu_reg_we", b1.reg_we, 4'b0001);
        check_eq("alu_invert0", b1.alu_invert, 0);
        check_eq("alu_exec_mem_rd", b1.mem_rd, 0);
        cyc();
        #1;
        check_eq("alu_2cyc_refetch", b1.ir_we, 1);
        check_eq("fetch_no_swap", b1.swap_p, 0);
        cyc();
        ir = 8'h0F;
        #1;
        check_eq("jmp_swap", b1.swap_p, 1);
        check_eq("jmp_no_flags_we", b1.flags_we, 0);
        cyc();
        #1;
        check_eq("jmp_swap_one_cycle", b1.swap_p, 0);
        check_eq("jmp_2cyc_refetch", b1.ir_we, 1);
        cyc();
        #1;
        check_eq("alu_i_reg_we", b1.reg_we, 4'b1000);
        check_eq("alu_i_invert", b1.alu_invert, 1);
        check_eq("alu_i_op", b1.alu_op, 4'd1);
        for (int k = 0; k < 5; k++) begin
            cyc();
            ir    = jc_ir[k];
            flags = jc_fl[k];
            #1;
            check_eq($sformatf("jc%0d_fetch", k), b1.ir_we, 1);
            cyc();
            #1;
            check_eq($sformatf("jc%0d_swap", k), b1.swap_p, jc_swap[k]);
        end

        // LDI r2, WORD_BYTES=4, no waits: 6 cycles, 5 IP increments
        do_reset();
        ir = 8'hA2;
        mem_ready = 1'b1;
        #1;
        n_ip = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                cyc();
                #1;
            end
            if (b4.ip_inc) n_ip++;
            if (c == 1) check_eq("ldi_exec_quiet", v4, 0);
            if (c >= 2) begin
                check_eq($sformatf("ldi_b%0d_sel", c - 2), b4.byte_sel, c - 2);
                check_eq($sformatf("ldi_b%0d_we", c - 2), b4.reg_we, 4'b0100);
                check_eq($sformatf("ldi_b%0d_rd", c - 2), b4.mem_rd, 1);
                check_eq($sformatf("ldi_b%0d_adp", c - 2), b4.addr_dp, 0);
            end
        end
        check_eq("ldi_ip_inc_count", n_ip, 5);
        cyc();
        #1;
        check_eq("ldi_6cyc_refetch", b4.ir_we, 1);

        // ST r1, WORD_BYTES=2, three wait cycles on byte 1: 7 cycles
        do_reset();
        ir = 8'h91;
        mem_ready = 1'b1;
        #1;
        check_eq("st_fetch", b2.ir_we, 1);
        cyc();
        #1;
        check_eq("st_exec_quiet", v2, 0);
        cyc();
        #1;
        check_eq("st_b0_wr", b2.mem_wr, 1);
        check_eq("st_b0_rd", b2.mem_rd, 0);
        check_eq("st_b0_sel", b2.byte_sel, 0);
        check_eq("st_b0_adp", b2.addr_dp, 1);
        check_eq("st_b0_oe", b2.reg_oe_d, 4'b0010);
        for (int w = 0; w < 4; w++) begin
            cyc();
            mem_ready = (w == 3);
            #1;
            check_eq($sformatf("st_w%0d_wr", w), b2.mem_wr, 1);
            check_eq($sformatf("st_w%0d_adp", w), b2.addr_dp, 1);
            check_eq($sformatf("st_w%0d_sel", w), b2.byte_sel, 1);
            check_eq($sformatf("st_w%0d_oe", w), b2.reg_oe_d, 4'b0010);
            check_eq($sformatf("st_w%0d_we", w), b2.reg_we, 0);
            check_eq($sformatf("st_w%0d_ipinc", w), b2.ip_inc, 0);
        end
        cyc();
        #1;
        check_eq("st_7cyc_refetch", b2.ir_we, 1);
        check_eq("st_refetch_rd", b2.mem_rd, 1);

        // LD r0 with mem_ready stuck low on the MAX_WAIT=5 instance
        do_reset();
        ir = 8'h80;
        mem_ready = 1'b1;
        #1;
        cyc();
        mem_ready = 1'b0;
        #1;
        for (int w = 0; w < 5; w++) begin
            cyc();
            #1;
            check_eq($sformatf("ld_w%0d_rd", w), b4.mem_rd, 1);
            check_eq($sformatf("ld_w%0d_adp", w), b4.addr_dp, 1);
            check_eq($sformatf("ld_w%0d_we", w), b4.reg_we, 0);
            check_eq($sformatf("ld_w%0d_halted", w), b4.halted, 0);
            check_eq($sformatf("ld_w%0d_berr", w), b4.bus_error, 0);
        end
        cyc();
        #1;
        check_eq("wd_halted", b4.halted, 1);
        check_eq("wd_bus_error", b4.bus_error, 1);
        check_eq("wd_mem_rd_drop", b4.mem_rd, 0);
        check_eq("wd_no_reg_we", b4.reg_we, 0);
        repeat (3) cyc();
        #1;
        check_eq("wd_sticky", b4.bus_error, 1);
        rst = 1'b1;
        #1;
        check_eq("wd_rst_quiet", v4, 0);
        cyc();
        rst = 1'b0;
        #1;
        check_eq("wd_rst_halted", b4.halted, 0);
        check_eq("wd_rst_berr", b4.bus_error, 0);
        check_eq("wd_rst_mem_rd", b4.mem_rd, 1);
        check_eq("wd_rst_adp", b4.addr_dp, 0);

        // HLT: halted from the cycle after EXEC, no bus activity
        do_reset();
        ir = 8'hFF;
        mem_ready = 1'b1;
        #1;
        cyc();
        #1;
        check_eq("hlt_exec_not_halted", b1.halted, 0);
        check_eq("hlt_exec_mem_rd", b1.mem_rd, 0);
        cyc();
        #1;
        check_eq("hlt_halted", b1.halted, 1);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (b1.mem_rd || b1.ir_we || !b1.halted) bad++;
            cyc();
            #1;
        end
        check_eq("hlt_stays_halted", bad, 0);

        // Reset during byte 2 of a 4-byte LDI
        do_reset();
        ir = 8'hA2;
        mem_ready = 1'b1;
        #1;
        repeat (4) cyc();
        #1;
        check_eq("mid_ldi_sel2", b4.byte_sel, 2);
        rst = 1'b1;
        #1;
        check_eq("mid_ldi_rst_quiet", v4, 0);
        cyc();
        rst = 1'b0;
        #1;
        check_eq("mid_ldi_after_sel", b4.byte_sel, 0);
        check_eq("mid_ldi_after_rd", b4.mem_rd, 1);
        check_eq("mid_ldi_after_adp", b4.addr_dp, 0);
        check_eq("mid_ldi_after_fetch", b4.ir_we, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
